// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control FSM.
// State codes, opcodes, ALU/mux select encodings and the control bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_TRAP      = 4'd12,
    S_JUMP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // Unsupported opcodes fall into TRAP and stay there until reset.
  function automatic state_t dispatch(input logic [5:0] op);
    state_t s;
    case (op)
      OP_RTYPE:      s = S_R_EXEC;
      OP_LW, OP_SW:  s = S_MEM_ADDR;
      OP_BEQ:        s = S_BRANCH;
      OP_J:          s = S_JUMP;
      OP_ADDI:       s = S_ADDI_EXEC;
      default:       s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Output decoder: maps the current FSM state (plus mem_ready in FETCH)
// onto the full datapath control vector.
import mc_ctrl_pkg::*;

module mc_ctrl_outdec (
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_OUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: state register and next-state logic.
// Outputs are decoded from state so an async reset drops every strobe at once.
import mc_ctrl_pkg::*;

module mc_main_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_t cur;
  state_t nxt;
  ctrl_t  ctrl;

  // The branch decision is made in the datapath (pc_write_cond & zero).
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:      nxt = S_FETCH;
      S_FETCH:     if (mem_ready) nxt = S_DECODE;
      S_DECODE:    nxt = dispatch(opcode);
      S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) nxt = S_MEM_WB;
      S_MEM_WB:    nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready) nxt = S_FETCH;
      S_R_EXEC:    nxt = S_R_WB;
      S_R_WB:      nxt = S_FETCH;
      S_ADDI_EXEC: nxt = S_ADDI_WB;
      S_ADDI_WB:   nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_JUMP:      nxt = S_FETCH;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  mc_ctrl_outdec u_outdec (
    .state     (cur),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = ctrl.illegal;
  assign state         = cur;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed, table-driven bench for mc_main_ctrl with a few hand-written
// sequences for stalls and asynchronous reset mid-instruction.
module tb_mc_main_ctrl;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DEC    = 4'd2;
  localparam logic [3:0] ST_MADDR  = 4'd3;
  localparam logic [3:0] ST_MRD    = 4'd4;
  localparam logic [3:0] ST_MWB    = 4'd5;
  localparam logic [3:0] ST_MWR    = 4'd6;
  localparam logic [3:0] ST_REX    = 4'd7;
  localparam logic [3:0] ST_RWB    = 4'd8;
  localparam logic [3:0] ST_AEX    = 4'd9;
  localparam logic [3:0] ST_AWB    = 4'd10;
  localparam logic [3:0] ST_BR     = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;
  localparam logic [3:0] ST_JMP    = 4'd13;

  localparam logic [5:0] R_OP  = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J_OP  = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] BAD   = 6'b111111;

  // {pw,pwc,iord,mr,mw,irw,m2r,rdst,rw,asa,asb[2],aop[2],psrc[2],ill}
  localparam logic [16:0] C_ZERO   = 17'b0;
  localparam logic [16:0] C_FETCH1 =
    {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_FETCH0 =
    {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_DEC    =
    {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MADDR  =
    {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MRD    =
    {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MWB    =
    {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MWR    =
    {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_REX    =
    {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] C_RWB    =
    {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_AEX    = C_MADDR;
  localparam logic [16:0] C_AWB    =
    {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_BR     =
    {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] C_JMP    =
    {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] C_TRAP   = 17'b1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic        zf;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal;
  logic [3:0] state;

  int   nvec = 0;
  int   nmis = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mc_main_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .state         (state)
  );

  task automatic add(input logic r, input logic [5:0] op,
                     input logic rdy, input logic zf,
                     input logic [3:0] st, input logic [16:0] ctl);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.zf = zf;
    v.st = st; v.ctl = ctl;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] es,
                       input logic [16:0] ec);
    logic [16:0] act;
    act = {pc_write, pc_write_cond, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, illegal};
    nvec++;
    if (state !== es || act !== ec || (mem_read && mem_write)) begin
      nmis++;
      $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
               name, state, act, es, ec);
    end
  endtask

  initial begin
    bit hit;
    rst = 1'b1; opcode = R_OP; zero = 1'b0; mem_ready = 1'b1;

    // reset, then release: FETCH appears after the second edge
    add(1, R_OP, 1, 0, ST_IDLE,  C_ZERO);
    add(0, R_OP, 1, 0, ST_IDLE,  C_ZERO);
    // R-type, 4 cycles
    add(0, R_OP, 1, 0, ST_FETCH, C_FETCH1);
    add(0, R_OP, 1, 0, ST_DEC,   C_DEC);
    add(0, R_OP, 1, 0, ST_REX,   C_REX);
    add(0, R_OP, 1, 0, ST_RWB,   C_RWB);
    // lw with 3 wait cycles in MEM_READ, 8 cycles
    add(0, LW,   1, 0, ST_FETCH, C_FETCH1);
    add(0, LW,   1, 0, ST_DEC,   C_DEC);
    add(0, LW,   1, 0, ST_MADDR, C_MADDR);
    add(0, LW,   0, 0, ST_MRD,   C_MRD);
    add(0, LW,   0, 0, ST_MRD,   C_MRD);
    add(0, LW,   0, 0, ST_MRD,   C_MRD);
    add(0, LW,   1, 0, ST_MRD,   C_MRD);
    add(0, LW,   1, 0, ST_MWB,   C_MWB);
    // beq, 3 cycles
    add(0, BEQ,  1, 0, ST_FETCH, C_FETCH1);
    add(0, BEQ,  1, 1, ST_DEC,   C_DEC);
    add(0, BEQ,  1, 1, ST_BR,    C_BR);
    // j, 3 cycles
    add(0, J_OP, 1, 0, ST_FETCH, C_FETCH1);
    add(0, J_OP, 1, 0, ST_DEC,   C_DEC);
    add(0, J_OP, 1, 0, ST_JMP,   C_JMP);
    // sw with 2-cycle fetch stall and 1-cycle write stall
    add(0, SW,   0, 0, ST_FETCH, C_FETCH0);
    add(0, SW,   0, 0, ST_FETCH, C_FETCH0);
    add(0, SW,   1, 0, ST_FETCH, C_FETCH1);
    add(0, SW,   1, 0, ST_DEC,   C_DEC);
    add(0, SW,   1, 0, ST_MADDR, C_MADDR);
    add(0, SW,   0, 0, ST_MWR,   C_MWR);
    add(0, SW,   1, 0, ST_MWR,   C_MWR);
    // addi, 4 cycles
    add(0, ADDI, 1, 0, ST_FETCH, C_FETCH1);
    add(0, ADDI, 1, 0, ST_DEC,   C_DEC);
    add(0, ADDI, 1, 0, ST_AEX,   C_AEX);
    add(0, ADDI, 1, 0, ST_AWB,   C_AWB);
    // illegal opcode: TRAP holds, only illegal set
    add(0, BAD,  1, 0, ST_FETCH, C_FETCH1);
    add(0, BAD,  1, 0, ST_DEC,   C_DEC);
    for (int i = 0; i < 12; i++)
      add(0, (i % 2) ? R_OP : BAD, i % 3 == 0, i % 2 == 0,
          ST_TRAP, C_TRAP);
    add(1, BAD,  1, 0, ST_IDLE,  C_ZERO);
    add(0, LW,   1, 0, ST_IDLE,  C_ZERO);
    // reset during a stalled load read: strobes drop at once
    add(0, LW,   1, 0, ST_FETCH, C_FETCH1);
    add(0, LW,   1, 0, ST_DEC,   C_DEC);
    add(0, LW,   1, 0, ST_MADDR, C_MADDR);
    add(0, LW,   0, 0, ST_MRD,   C_MRD);
    add(1, LW,   0, 0, ST_IDLE,  C_ZERO);
    add(0, LW,   1, 0, ST_IDLE,  C_ZERO);
    add(0, LW,   1, 0, ST_FETCH, C_FETCH1);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; opcode = tbl[i].op;
      mem_ready = tbl[i].rdy; zero = tbl[i].zf;
      #1;
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].ctl);
    end

    // sw stalled in MEM_WRITE, then rst pulsed mid-cycle
    @(negedge clk);
    rst = 1'b1; #1;
    check("seq_rst", ST_IDLE, C_ZERO);
    rst = 1'b0; opcode = SW; mem_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (state == ST_MADDR) mem_ready = 1'b0;
      #1;
      hit = (state == ST_MWR);
    end
    if (!hit) begin
      nvec++; nmis++;
      $display("FAIL seq_wait: state=%0d never reached %0d", state, ST_MWR);
    end
    check("seq_mwr", ST_MWR, C_MWR);
    @(posedge clk); #2;
    check("seq_mwr_hold", ST_MWR, C_MWR);
    rst = 1'b1; #1;
    check("seq_async_rst", ST_IDLE, C_ZERO);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    check("seq_refetch", ST_FETCH, C_FETCH1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
